// File: rtl/spi_master.sv
// SPI mode-0 master: serialises tx_frame on mosi while deserialising miso, sclk from a divide counter.
// Optional SPI_MASTER_LSB_FIRST_EN selects LSB-first framing in both directions (default MSB-first).
`ifndef MASTER_FRAME_WIDTH
`define MASTER_FRAME_WIDTH 8
`endif

module spi_master #(
  parameter int unsigned FRAME_WIDTH = `MASTER_FRAME_WIDTH,
  parameter int unsigned CLK_DIV     = 4
) (
  input  logic                   sysclk,
  input  logic                   rst,
  input  logic                   tx_start,
  input  logic [FRAME_WIDTH-1:0] tx_frame,
  output logic                   tx_ready,
  output logic [FRAME_WIDTH-1:0] rx_frame,
  output logic                   rx_valid,
  output logic                   sclk,
  output logic                   cs,
  output logic                   mosi,
  input  logic                   miso
);

  localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BIT_W = (FRAME_WIDTH > 2) ? $clog2(FRAME_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_WIDTH - 1);
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam int unsigned FIRST_IDX = 0;
`else
  localparam int unsigned FIRST_IDX = FRAME_WIDTH - 1;
`endif

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                 state, state_nxt;
  logic [DIV_W-1:0]       div_cnt, div_nxt;
  logic [BIT_W-1:0]       bit_cnt, bit_nxt;
  logic                   last_half, last_nxt;
  logic [FRAME_WIDTH-1:0] tx_sr, tx_sr_nxt;
  logic [FRAME_WIDTH-1:0] rx_sr, rx_sr_nxt;
  logic [FRAME_WIDTH-1:0] rx_frame_nxt;
  logic                   rx_valid_nxt, tx_ready_nxt, sclk_nxt, cs_nxt, mosi_nxt;
  logic                   div_end;

  // Advance the TX register so the next bit to send sits at FIRST_IDX.
  function automatic logic [FRAME_WIDTH-1:0] shift_out(input logic [FRAME_WIDTH-1:0] sr);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {1'b0, sr[FRAME_WIDTH-1:1]};
`else
    return {sr[FRAME_WIDTH-2:0], 1'b0};
`endif
  endfunction

  function automatic logic [FRAME_WIDTH-1:0] shift_in(input logic [FRAME_WIDTH-1:0] sr,
                                                       input logic b);
`ifdef SPI_MASTER_LSB_FIRST_EN
    return {b, sr[FRAME_WIDTH-1:1]};
`else
    return {sr[FRAME_WIDTH-2:0], b};
`endif
  endfunction

  always_comb begin
    state_nxt    = state;
    div_nxt      = div_cnt;
    bit_nxt      = bit_cnt;
    last_nxt     = last_half;
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    rx_frame_nxt = rx_frame;
    rx_valid_nxt = 1'b0;
    tx_ready_nxt = tx_ready;
    sclk_nxt     = sclk;
    cs_nxt       = cs;
    mosi_nxt     = mosi;
    div_end      = (div_cnt == DIV_LAST);

    case (state)
      IDLE: begin
        if (tx_start) begin
          state_nxt    = SETUP;
          tx_sr_nxt    = tx_frame;
          rx_sr_nxt    = '0;
          mosi_nxt     = tx_frame[FIRST_IDX];
          cs_nxt       = 1'b0;
          tx_ready_nxt = 1'b0;
          div_nxt      = '0;
          bit_nxt      = '0;
          last_nxt     = 1'b0;
        end
      end

      SETUP: begin
        div_nxt = div_cnt + DIV_W'(1);
        if (div_end) begin
          div_nxt   = '0;
          sclk_nxt  = 1'b1;
          rx_sr_nxt = shift_in(rx_sr, miso);
          state_nxt = XFER;
        end
      end

      // High half ends in a falling edge; low half ends in a rising edge or,
      // once the last bit has fallen, in the move to HOLD.
      XFER: begin
        div_nxt = div_cnt + DIV_W'(1);
        if (div_end) begin
          div_nxt = '0;
          if (sclk) begin
            sclk_nxt = 1'b0;
            if (bit_cnt != BIT_LAST) begin
              tx_sr_nxt = shift_out(tx_sr);
              mosi_nxt  = tx_sr_nxt[FIRST_IDX];
              bit_nxt   = bit_cnt + BIT_W'(1);
            end else begin
              last_nxt = 1'b1;
            end
          end else if (last_half) begin
            state_nxt = HOLD;
          end else begin
            sclk_nxt  = 1'b1;
            rx_sr_nxt = shift_in(rx_sr, miso);
          end
        end
      end

      HOLD: begin
        div_nxt = div_cnt + DIV_W'(1);
        if (div_end) begin
          div_nxt      = '0;
          state_nxt    = IDLE;
          cs_nxt       = 1'b1;
          mosi_nxt     = 1'b0;
          rx_frame_nxt = rx_sr;
          rx_valid_nxt = 1'b1;
          tx_ready_nxt = 1'b1;
          last_nxt     = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      last_half <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      rx_frame  <= '0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b1;
      sclk      <= 1'b0;
      cs        <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_cnt   <= div_nxt;
      bit_cnt   <= bit_nxt;
      last_half <= last_nxt;
      tx_sr     <= tx_sr_nxt;
      rx_sr     <= rx_sr_nxt;
      rx_frame  <= rx_frame_nxt;
      rx_valid  <= rx_valid_nxt;
      tx_ready  <= tx_ready_nxt;
      sclk      <= sclk_nxt;
      cs        <= cs_nxt;
      mosi      <= mosi_nxt;
    end
  end

endmodule

// File: doc/spi_master.md
# spi_master

SPI mode-0 (CPOL=0, CPHA=0) master that is the initiator for the board's SPI slave, so the pair can run on one Zybo Z7-20 or across PMOD JA. It accepts a parallel frame from on-chip logic and serialises it on `mosi` while clocking `sclk` and holding `cs` low. At the same time it deserialises `miso` and returns the received frame with a one-cycle valid pulse. Everything runs on `sysclk`; `sclk` is produced by a divide counter, not a second clock domain.

## Interface
- `FRAME_WIDTH`, default `` `MASTER_FRAME_WIDTH `` (8): bits per transaction; must be ≥ 2.
- `CLK_DIV`, default 4: `sysclk` cycles per `sclk` half-period; must be ≥ 2.
- `sysclk` input 1: system clock; all logic is on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `tx_start` input 1: request a transaction; it is accepted only when `tx_ready` = 1.
- `tx_frame` input FRAME_WIDTH: frame to send; captured in the accept cycle.
- `tx_ready` output 1: 1 when idle and able to accept `tx_start`.
- `rx_frame` output FRAME_WIDTH: last received frame; holds its value until the next completion.
- `rx_valid` output 1: one-cycle pulse when `rx_frame` updates.
- `sclk` output 1: SPI clock, registered, idle low.
- `cs` output 1: chip select, active low, registered, idle high.
- `mosi` output 1: serial data out, registered, idle low.
- `miso` input 1: serial data in from the slave.

## Operation
- FSM states: IDLE, SETUP, XFER, HOLD. A half-period counter `div_cnt` (0..CLK_DIV-1) and a bit counter `bit_cnt` (0..FRAME_WIDTH-1) drive the transitions.
- IDLE:
  - `tx_ready` = 1.
  - On `tx_start` = 1: load the TX shift register with `tx_frame`, then go to SETUP.
  - `tx_start` while not in IDLE is ignored and not queued.
- SETUP (CLK_DIV cycles):
  - `cs` = 0.
  - `mosi` = first bit (MSB by default).
  - `sclk` = 0.
  - Then go to XFER.
- XFER, alternating half-periods of CLK_DIV cycles each:
  - Rising edge (`sclk` 0→1): on that same `sysclk` edge, shift `miso` into the RX register.
  - Falling edge (`sclk` 1→0): if bits remain, drive `mosi` with the next bit and increment `bit_cnt`.
  - After the falling edge of bit FRAME_WIDTH-1, go to HOLD.
- HOLD (CLK_DIV cycles):
  - `cs` stays 0, `sclk` = 0.
  - On exit: `cs` = 1, `mosi` = 0, `rx_frame` ← RX register, `rx_valid` = 1 for that cycle, `tx_ready` = 1, return to IDLE.
- Back-to-back operation: `tx_start` in the completion cycle is accepted. `cs` is then high for exactly one cycle before the next SETUP.
- Reset, asynchronous and valid at any point including mid-frame:
  - State = IDLE.
  - `cs` = 1, `sclk` = 0, `mosi` = 0.
  - `tx_ready` = 1, `rx_valid` = 0, `rx_frame` = 0.
  - All counters and shift registers are cleared. A partial frame is discarded and produces no `rx_valid`.

## Timing
- Cycle 0 is the edge where `tx_start` & `tx_ready` are sampled.
- Cycle 1: `cs` = 0, `mosi` = first bit, `tx_ready` = 0.
- Rising edge of bit k (k = 0..FRAME_WIDTH-1): cycle 1 + CLK_DIV + 2k·CLK_DIV.
- Falling edge of bit k: CLK_DIV cycles after its rising edge.
- Completion cycle (`cs` = 1, `rx_valid` = 1, `tx_ready` = 1): 1 + (2·FRAME_WIDTH + 2)·CLK_DIV. With defaults this is cycle 73.
- `sclk` duty cycle is exactly 50 %. Frequency = f_sysclk / (2·CLK_DIV).
- Every output is a flop output; no combinational path runs from an input to an output.
- `miso` is not synchronised. The slave must hold `miso` stable for at least 1 `sysclk` cycle before each `sclk` rising edge.

## Configuration
- `SPI_MASTER_LSB_FIRST_EN`:
  - Defined: the TX register shifts right and `mosi` sends bit 0 first. RX bits enter at the MSB end and shift right, so `rx_frame[0]` is the first bit received.
  - Undefined (default): MSB-first on both directions, matching the slave's default framing. Timing is identical in both cases.

## Test plan
- Loopback (`miso` tied to `mosi`), FRAME_WIDTH=8, CLK_DIV=2, `tx_frame`=0xA5 → `mosi` sequence 1,0,1,0,0,1,0,1; `rx_frame`=0xA5; `rx_valid` only at cycle 37; 8 `sclk` rising edges.
- Slave model returning 0x3C while master sends 0xFF → `rx_frame`=0x3C; `cs` low for cycles 1..36; `sclk` is 0 whenever `cs`=1.
- `tx_start` pulsed at cycle 10 of a busy frame → ignored; exactly one `rx_valid`; `tx_ready` stays 0 until cycle 37.
- Back-to-back: `tx_start` held high with frames 0x01 then 0x80 → `cs` high for exactly 1 cycle (cycle 37); second `rx_valid` at cycle 74; loopback gives 0x01, then 0x80.
- `rst` asserted mid-XFER (cycle 15, between clock edges) → immediately `cs`=1, `sclk`=0, `mosi`=0, `tx_ready`=1, `rx_frame`=0; no `rx_valid`; the next frame, 0x5A, completes correctly.
- With `SPI_MASTER_LSB_FIRST_EN`, `tx_frame`=0x01 → `mosi` =1 on bit 0 only; loopback `rx_frame`=0x01.
